// File: rtl/wave_column_engine_pkg.sv
// Shared definitions for the wave-equation column engine: FSM encoding and
// fixed-point constants for the default 1.17 node format.
package wave_column_engine_pkg;

  localparam int unsigned DefDataW = 18;
  localparam int unsigned DefFracW = 17;

  // 1.0 in the default fixed-point format
  localparam int One    = 1 << DefFracW;
  // Signed saturation limits for the default node width
  localparam int SatMax = (1 << (DefDataW - 1)) - 1;
  localparam int SatMin = -(1 << (DefDataW - 1));

  typedef enum logic [2:0] {
    StIdle,
    StPrefetch,
    StRead,
    StWait,
    StCalc,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/wave_col_ram.sv
// Simple dual-port node RAM: one write port, one read port with a registered
// 1-cycle read. The output holds its value until the next enabled read.
module wave_col_ram #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port (read-before-write on collision)
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/wave_column_engine.sv
// One grid column of the 2D wave-equation solver. Holds u[n] (cur) and
// u[n-1] (prev) for its rows and sweeps them bottom-to-top once per step,
// coupling to the left/right columns through their center values.
module wave_column_engine
  import wave_column_engine_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned FRAC_W = DefFracW,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W:0]          height,
  input  logic [DATA_W-1:0]        rho_eff,
  input  logic [3:0]               damp_shift,
  input  logic [ADDR_W-1:0]        tap_row,
  input  logic                     step_start,
  input  logic                     init_we,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic signed [DATA_W-1:0] init_data,
  input  logic signed [DATA_W-1:0] node_left_in,
  input  logic signed [DATA_W-1:0] node_right_in,
  output logic signed [DATA_W-1:0] node_out,
  output logic                     busy,
  output logic                     step_done,
  output logic signed [DATA_W-1:0] tap_value
);

  localparam int unsigned LapW  = DATA_W + 3;
  localparam int unsigned WideW = LapW + DATA_W + 1;
  localparam logic [ADDR_W:0] HeightMin = (ADDR_W + 1)'(2);
  localparam logic [ADDR_W:0] HeightMax = (ADDR_W + 1)'(DEPTH);
  localparam logic signed [DATA_W-1:0] SatHi = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SatLo = {1'b1, {(DATA_W - 1){1'b0}}};

  state_e state_q, state_d;

  logic [ADDR_W-1:0]        row_q;
  logic [ADDR_W:0]          height_q, height_clamped;
  logic [DATA_W-1:0]        rho_q;
  logic [3:0]               damp_q;
  logic signed [DATA_W-1:0] center_q, down_q, u_next_q, tap_q, u_next_d, up;
  logic signed [DATA_W-1:0] cur_q, prev_q, cur_wdata, prev_wdata;
  logic                     busy_q, done_q, idle, last_row;
  logic                     ram_we, cur_re, prev_re;
  logic [ADDR_W-1:0]        waddr, cur_raddr;

  logic signed [LapW-1:0]   lap;
  logic signed [WideW-1:0]  rho_w, prod, term, vel, vel_d, sum;

  assign idle     = (state_q == StIdle);
  assign last_row = ({1'b0, row_q} == height_q - (ADDR_W + 1)'(1));
  // Fixed edge above the top row
  assign up       = last_row ? '0 : cur_q;

  assign node_out  = center_q;
  assign busy      = busy_q;
  assign step_done = done_q;
  assign tap_value = tap_q;

  // Clamp the requested height to 2..DEPTH
  always_comb begin
    height_clamped = height;
    if (height < HeightMin)      height_clamped = HeightMin;
    else if (height > HeightMax) height_clamped = HeightMax;
  end

  // RAM port steering: host loads in IDLE, row write-back in WRITE
  always_comb begin
    ram_we     = (idle && init_we) || (state_q == StWrite);
    waddr      = idle ? init_addr : row_q;
    cur_wdata  = idle ? init_data : u_next_q;
    prev_wdata = idle ? init_data : center_q;
    cur_re     = (idle && step_start) || (state_q == StRead && !last_row);
    cur_raddr  = idle ? '0 : row_q + ADDR_W'(1);
    prev_re    = (state_q == StRead);
  end

  wave_col_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_cur_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (cur_wdata),
    .re    (cur_re),
    .raddr (cur_raddr),
    .q     (cur_q)
  );

  wave_col_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_prev_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (prev_wdata),
    .re    (prev_re),
    .raddr (row_q),
    .q     (prev_q)
  );

  // Node update: laplacian coupling plus damped velocity, saturated
  always_comb begin
    lap   = LapW'(node_left_in) + LapW'(node_right_in) + LapW'(up) + LapW'(down_q)
          - (LapW'(center_q) <<< 2);
    rho_w = WideW'({1'b0, rho_q});
    prod  = WideW'(lap) * rho_w;
    term  = prod >>> FRAC_W;
    vel   = WideW'(center_q) - WideW'(prev_q);
    vel_d = (damp_q == 4'd0) ? vel : vel - (vel >>> damp_q);
    sum   = WideW'(center_q) + vel_d + term;
    if (sum > WideW'(SatHi))      u_next_d = SatHi;
    else if (sum < WideW'(SatLo)) u_next_d = SatLo;
    else                          u_next_d = sum[DATA_W-1:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (step_start) state_d = StPrefetch;
      StPrefetch: state_d = StRead;
      StRead:     state_d = StWait;
      StWait:     state_d = StCalc;
      StCalc:     state_d = StWrite;
      StWrite:    state_d = last_row ? StDone : StRead;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Datapath registers: step parameters, row window, result and status
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q    <= '0;
      height_q <= HeightMin;
      rho_q    <= '0;
      damp_q   <= '0;
      center_q <= '0;
      down_q   <= '0;
      u_next_q <= '0;
      tap_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (step_start) begin
            height_q <= height_clamped;
            rho_q    <= rho_eff;
            damp_q   <= damp_shift;
            row_q    <= '0;
            busy_q   <= 1'b1;
          end
        end
        StPrefetch: begin
          center_q <= cur_q;
          down_q   <= '0;
        end
        StCalc: u_next_q <= u_next_d;
        StWrite: begin
          down_q   <= center_q;
          center_q <= up;
          if (row_q == tap_row) tap_q <= u_next_q;
          if (!last_row) row_q <= row_q + ADDR_W'(1);
        end
        StDone: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_column_engine.sv
// Scoreboard bench for wave_column_engine: the driver runs a behavioural
// model of each step and queues expected node_out/tap/latency values; an
// independent monitor checks them as the DUT presents them.
module tb_wave_column_engine;
  import wave_column_engine_pkg::*;

  localparam int DATA_W = 18;
  localparam int FRAC_W = 17;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [ADDR_W:0]          height = '0;
  logic [DATA_W-1:0]        rho_eff = '0;
  logic [3:0]               damp_shift = '0;
  logic [ADDR_W-1:0]        tap_row = '0;
  logic                     step_start = 1'b0;
  logic                     init_we = 1'b0;
  logic [ADDR_W-1:0]        init_addr = '0;
  logic signed [DATA_W-1:0] init_data = '0;
  logic signed [DATA_W-1:0] node_left_in = '0;
  logic signed [DATA_W-1:0] node_right_in = '0;
  logic signed [DATA_W-1:0] node_out;
  logic                     busy;
  logic                     step_done;
  logic signed [DATA_W-1:0] tap_value;

  wave_column_engine #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .height        (height),
    .rho_eff       (rho_eff),
    .damp_shift    (damp_shift),
    .tap_row       (tap_row),
    .step_start    (step_start),
    .init_we       (init_we),
    .init_addr     (init_addr),
    .init_data     (init_data),
    .node_left_in  (node_left_in),
    .node_right_in (node_right_in),
    .node_out      (node_out),
    .busy          (busy),
    .step_done     (step_done),
    .tap_value     (tap_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     h;
    longint tap;
  } step_rec_t;

  step_rec_t step_q[$];
  longint    node_q[$];
  longint    m_cur[DEPTH];
  longint    m_prev[DEPTH];
  longint    m_tap = 0;
  int        checks = 0;
  int        passes = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_rows(input int n);
    for (int i = 0; i < n; i++) if (node_q.size() > 0) void'(node_q.pop_front());
  endtask

  // Reference model of one time step over whole-column arrays.
  // applied < 0 means the step completes; otherwise only rows below it are
  // written before a reset aborts the step.
  task automatic model_step(input int h_in, input int rho, input int ds, input int left,
                            input int right, input int trow, input int applied);
    int        h, n;
    longint    nv[DEPTH];
    longint    up, down, lap, term, vel, veld, s;
    step_rec_t rec;
    h = (h_in < 2) ? 2 : ((h_in > DEPTH) ? DEPTH : h_in);
    for (int r = 0; r < h; r++) begin
      node_q.push_back(m_cur[r]);
      up   = (r == h - 1) ? 0 : m_cur[r + 1];
      down = (r == 0) ? 0 : m_cur[r - 1];
      lap  = left + right + up + down - 4 * m_cur[r];
      term = (lap * rho) >>> FRAC_W;
      vel  = m_cur[r] - m_prev[r];
      veld = (ds == 0) ? vel : vel - (vel >>> ds);
      s    = m_cur[r] + veld + term;
      if (s > SatMax) s = SatMax;
      if (s < SatMin) s = SatMin;
      nv[r] = s;
    end
    n = (applied < 0) ? h : applied;
    for (int r = 0; r < n; r++) begin
      m_prev[r] = m_cur[r];
      m_cur[r]  = nv[r];
      if (r == trow) m_tap = nv[r];
    end
    if (applied >= 0) m_tap = 0;
    rec.h   = h;
    rec.tap = m_tap;
    step_q.push_back(rec);
  endtask

  task automatic load(input int addr, input int val);
    init_addr = ADDR_W'(addr);
    init_data = DATA_W'(val);
    init_we   = 1'b1;
    tick;
    init_we   = 1'b0;
    m_cur[addr]  = val;
    m_prev[addr] = val;
  endtask

  task automatic clear_all;
    for (int a = 0; a < DEPTH; a++) load(a, 0);
  endtask

  // mid: pulse step_start and init_we while busy; abort_row >= 0: reset in
  // that row's CALC cycle.
  task automatic run_step(input int h, input int rho, input int ds, input int left,
                          input int right, input int trow, input bit mid, input int abort_row);
    bit finished;
    model_step(h, rho, ds, left, right, trow, abort_row);
    height        = (ADDR_W + 1)'(h);
    rho_eff       = DATA_W'(rho);
    damp_shift    = 4'(ds);
    tap_row       = ADDR_W'(trow);
    node_left_in  = DATA_W'(left);
    node_right_in = DATA_W'(right);
    step_start    = 1'b1;
    tick;
    step_start    = 1'b0;
    // Latched parameters must not follow later input changes
    height     = (ADDR_W + 1)'($urandom);
    rho_eff    = DATA_W'($urandom);
    damp_shift = 4'($urandom);
    finished = 1'b0;
    for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
      if (abort_row >= 0 && cyc == 4 + 4 * abort_row) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("busy after reset", longint'(busy), 0);
        check("tap_value after reset", longint'(tap_value), 0);
        check("node_out after reset", longint'(node_out), 0);
        finished = 1'b1;
      end else if (step_done) begin
        finished = 1'b1;
      end else begin
        step_start = mid && (cyc == 9);
        init_we    = mid && (cyc == 13);
        init_addr  = ADDR_W'($urandom);
        init_data  = DATA_W'($urandom);
        tick;
      end
    end
    step_start = 1'b0;
    init_we    = 1'b0;
    if (!finished) begin
      checks++;
      $display("FAIL step_done timeout: no pulse within 400 cycles, expected one");
    end
    tick;
  endtask

  // Monitor: tracks each step from busy rising and checks queued values
  initial begin
    step_rec_t rec;
    bit in_step = 1'b0;
    bit prev_busy = 1'b0;
    int c = 0;
    int rows_seen = 0;
    rec.h = 0;
    rec.tap = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (in_step) drop_rows(rec.h - rows_seen);
        in_step   = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (!in_step && busy && !prev_busy) begin
          if (step_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected step: busy rose with no step issued");
          end else begin
            rec = step_q.pop_front();
            in_step = 1'b1;
            c = 1;
            rows_seen = 0;
          end
        end else if (in_step) begin
          c++;
        end
        if (in_step) begin
          if (c >= 4 && c % 4 == 0 && rows_seen < rec.h) begin
            if (node_q.size() > 0) check("node_out", longint'(node_out), node_q.pop_front());
            rows_seen++;
          end
          if (step_done) begin
            check("step_done cycle", c, 2 + 4 * rec.h + 1);
            check("tap_value", longint'(tap_value), rec.tap);
            check("busy at step_done", longint'(busy), 0);
            in_step = 1'b0;
          end else if (!busy) begin
            checks++;
            $display("FAIL busy dropped: at cycle %0d without step_done, required high", c);
            drop_rows(rec.h - rows_seen);
            in_step = 1'b0;
          end else if (c > 4 * DEPTH + 10) begin
            checks++;
            $display("FAIL step length: cycle %0d without step_done, required %0d", c,
                     2 + 4 * rec.h + 1);
            drop_rows(rec.h - rows_seen);
            in_step = 1'b0;
          end
        end else if (step_done) begin
          checks++;
          $display("FAIL stray step_done: step_done=1 outside a step, required 0");
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Driver
  initial begin
    int h, rho, ds, left, right, trow;
    for (int a = 0; a < DEPTH; a++) begin
      m_cur[a]  = 0;
      m_prev[a] = 0;
    end
    repeat (3) tick;
    reset = 1'b0;
    check("reset node_out", longint'(node_out), 0);
    check("reset busy", longint'(busy), 0);
    check("reset step_done", longint'(step_done), 0);
    check("reset tap_value", longint'(tap_value), 0);

    clear_all;
    run_step(8, 0, 0, 0, 0, 3, 1'b0, -1);
    clear_all;
    load(3, One / 2);
    run_step(8, 8192, 0, 0, 0, 3, 1'b0, -1);
    clear_all;
    run_step(8, 8192, 0, One / 4, One / 4, 0, 1'b0, -1);
    run_step(8, 0, 2, 0, 0, 5, 1'b0, -1);
    clear_all;
    load(3, SatMax);
    run_step(8, SatMax, 0, SatMin, SatMin, 3, 1'b0, -1);
    run_step(8, 4096, 1, 1000, -2000, 2, 1'b1, -1);
    run_step(8, 4096, 1, 1000, -2000, 2, 1'b0, 4);
    run_step(8, 4096, 1, 1000, -2000, 2, 1'b0, -1);

    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < 3; j++)
        load(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 262143)) - 131072);
      h     = int'($urandom_range(0, 20));
      rho   = (k % 4 == 0) ? int'($urandom_range(0, 262143)) : int'($urandom_range(0, 20000));
      ds    = int'($urandom_range(0, 15));
      left  = int'($urandom_range(0, 262143)) - 131072;
      right = int'($urandom_range(0, 262143)) - 131072;
      trow  = int'($urandom_range(0, DEPTH - 1));
      run_step(h, rho, ds, left, right, trow, (k % 5 == 0), -1);
    end
    run_step(DEPTH, 0, 0, 0, 0, 0, 1'b0, -1);

    repeat (5) tick;
    check("pending step records", step_q.size(), 0);
    check("pending node values", node_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
